dcache_miss_handler: RTL

Core-side initiator for data-cache misses on the shared miss interface to the memory hierarchy. It accepts one miss at a time from the D$ controller, optionally writes back a dirty victim line, issues the refill load, and filters and returns the matching response to the D$. It sits between the D$ controller and the core's `dcache_req_valid_miss`, `dcache_req_info_miss` and `rsp_*_miss` ports.

---
 rtl/dcache_miss_handler.sv | 94 +++++++++
 1 files changed

// File: rtl/dcache_miss_handler.sv
// dcache_miss_handler: single-outstanding D$ miss engine (optional victim write-back, refill, response filter).
// Define DCACHE_MISS_HANDLER_TIMEOUT_EN to add a per-request watchdog of TIMEOUT_CYCLES cycles.
module dcache_miss_handler #(
   parameter int DCACHE_LINE_ADDR   = 26,
   parameter int DCACHE_LINE_WIDTH  = 512,
   parameter int THR_PER_CORE_WIDTH = 2,
   parameter int TIMEOUT_CYCLES     = 256
) (
   input  logic                                                              clock,
   input  logic                                                              reset,
   input  logic                                                              miss_valid,
   output logic                                                              miss_ready,
   input  logic [DCACHE_LINE_ADDR-1:0]                                       miss_addr,
   input  logic [THR_PER_CORE_WIDTH-1:0]                                     miss_thread_id,
   input  logic                                                              evict_dirty,
   input  logic [DCACHE_LINE_ADDR-1:0]                                       evict_addr,
   input  logic [DCACHE_LINE_WIDTH-1:0]                                      evict_data,
   output logic                                                              dcache_req_valid_miss,
   output logic [DCACHE_LINE_ADDR+DCACHE_LINE_WIDTH+THR_PER_CORE_WIDTH:0]    dcache_req_info_miss,
   input  logic                                                              rsp_valid_miss,
   input  logic                                                              rsp_cache_id,
   input  logic [THR_PER_CORE_WIDTH-1:0]                                     rsp_thread_id,
   input  logic                                                              rsp_bus_error,
   input  logic [DCACHE_LINE_WIDTH-1:0]                                      rsp_data_miss,
   output logic                                                              fill_valid,
   output logic [DCACHE_LINE_WIDTH-1:0]                                      fill_data,
   output logic [DCACHE_LINE_ADDR-1:0]                                       fill_addr,
   output logic [THR_PER_CORE_WIDTH-1:0]                                     fill_thread_id,
   output logic                                                              fill_error
);
   typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, DONE} state_t;
   state_t state;
   logic   hit, tmo;
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end
   // fill_thread_id doubles as the latched requester used for response matching
   assign hit = rsp_valid_miss & rsp_cache_id & (rsp_thread_id == fill_thread_id);
`ifdef DCACHE_MISS_HANDLER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);
   logic [TO_W-1:0] cnt;
   assign tmo = cnt == TO_W'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clock) begin
      cnt <= (state == WB_WAIT || state == FILL_WAIT) ? cnt + 1'b1 : '0;
   end
`else
   assign tmo = 1'b0;
`endif
   always_ff @(posedge clock) begin
      if (reset) begin
         state                 <= IDLE;
         miss_ready            <= 1'b1;
         dcache_req_valid_miss <= 1'b0;
         fill_valid            <= 1'b0;
         fill_error            <= 1'b0;
      end else begin
         dcache_req_valid_miss <= 1'b0;
         fill_valid            <= 1'b0;
         case (state)
            IDLE: if (miss_valid) begin
               miss_ready            <= 1'b0;
               fill_addr             <= miss_addr;
               fill_thread_id        <= miss_thread_id;
               dcache_req_valid_miss <= 1'b1;
               dcache_req_info_miss  <= evict_dirty ? {evict_addr, 1'b1, evict_data, miss_thread_id}
                                                    : {miss_addr, 1'b0, {DCACHE_LINE_WIDTH{1'b0}}, miss_thread_id};
               state                 <= evict_dirty ? WB_REQ : FILL_REQ;
            end
            WB_REQ:   state <= WB_WAIT;
            FILL_REQ: state <= FILL_WAIT;
            WB_WAIT: if (hit && !rsp_bus_error) begin
               dcache_req_valid_miss <= 1'b1;
               dcache_req_info_miss  <= {fill_addr, 1'b0, {DCACHE_LINE_WIDTH{1'b0}}, fill_thread_id};
               state                 <= FILL_REQ;
            end else if (hit || tmo) begin
               fill_valid <= 1'b1;
               fill_error <= 1'b1;
               state      <= DONE;
            end
            FILL_WAIT: if (hit || tmo) begin
               fill_valid <= 1'b1;
               fill_error <= !hit || rsp_bus_error;
               fill_data  <= rsp_data_miss;
               state      <= DONE;
            end
            DONE: begin
               miss_ready <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
